// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
//   Bundles the control, byte-stream and instruction-memory write signals of
//   the boot loader so they travel as one port.
//
//   start_load    pulse: begin a new load session
//   rx_valid      rx_data valid this cycle (1-cycle strobe)
//   rx_data       received byte
//   imem_wren     instruction-memory write enable
//   imem_address  write address
//   imem_data     write data
//   cpu_reset     hold CPU in reset (high = held)
//   load_done     image loaded and checksum OK (level)
//   load_error    session failed (level)
//
//   master : drives start_load / rx_*, observes the loader outputs
//   slave  : the loader itself
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned INSTR_WIDTH = 20
);
   logic                   start_load;
   logic                   rx_valid;
   logic [7:0]             rx_data;
   logic                   imem_wren;
   logic [ADDR_WIDTH-1:0]  imem_address;
   logic [INSTR_WIDTH-1:0] imem_data;
   logic                   cpu_reset;
   logic                   load_done;
   logic                   load_error;

   modport master (
      output start_load,
      output rx_valid,
      output rx_data,
      input  imem_wren,
      input  imem_address,
      input  imem_data,
      input  cpu_reset,
      input  load_done,
      input  load_error
   );

   modport slave (
      input  start_load,
      input  rx_valid,
      input  rx_data,
      output imem_wren,
      output imem_address,
      output imem_data,
      output cpu_reset,
      output load_done,
      output load_error
   );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Fills instruction memory from a UART byte stream before the CPU runs.
//   Frame: LEN_HI, LEN_LO (N, big-endian), N x {B0,B1,B2}, CSUM.
//   Each triple becomes instr = {B0[3:0],B1,B2}; CSUM is the XOR of every
//   byte between LEN_LO and CSUM. The CPU is held in reset until a frame
//   has been fully written and its checksum matches.
//
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    imem_boot_loader_if.slave:
//            in : start_load, rx_valid, rx_data
//            out: imem_wren, imem_address, imem_data,
//                 cpu_reset, load_done, load_error
// ---------------------------------------------------------------------------
module imem_boot_loader #(
   parameter int unsigned ADDR_WIDTH     = 16,
   parameter int unsigned INSTR_WIDTH    = 20,
   parameter int unsigned MAX_INSTR      = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               reset,
   imem_boot_loader_if.slave  bus
);

   localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [3:0] StIdle  = 4'd0;
   localparam logic [3:0] StLenHi = 4'd1;
   localparam logic [3:0] StLenLo = 4'd2;
   localparam logic [3:0] StB0    = 4'd3;
   localparam logic [3:0] StB1    = 4'd4;
   localparam logic [3:0] StB2    = 4'd5;
   localparam logic [3:0] StCsum  = 4'd6;
   localparam logic [3:0] StDone  = 4'd7;
   localparam logic [3:0] StError = 4'd8;

   logic [3:0]             state_q,   state_d;
   logic [TimerWidth-1:0]  timer_q,   timer_d;
   logic [7:0]             xor_q,     xor_d;
   logic [7:0]             len_hi_q,  len_hi_d;
   logic [15:0]            remain_q,  remain_d;
   logic [3:0]             b0_lo_q,   b0_lo_d;
   logic [7:0]             b1_q,      b1_d;
   logic [ADDR_WIDTH-1:0]  cnt_q,     cnt_d;
   logic                   wren_q,    wren_d;
   logic [ADDR_WIDTH-1:0]  addr_q,    addr_d;
   logic [INSTR_WIDTH-1:0] data_q,    data_d;

   logic [15:0]            len_n;
   logic                   in_session;

   assign len_n      = {len_hi_q, bus.rx_data};
   assign in_session = (state_q == StLenHi) || (state_q == StLenLo) ||
                       (state_q == StB0)    || (state_q == StB1)    ||
                       (state_q == StB2)    || (state_q == StCsum);

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      xor_d    = xor_q;
      len_hi_d = len_hi_q;
      remain_d = remain_q;
      b0_lo_d  = b0_lo_q;
      b1_d     = b1_q;
      cnt_d    = cnt_q;
      wren_d   = 1'b0;
      addr_d   = addr_q;
      data_d   = data_q;

      case (state_q)
         StIdle, StDone, StError: begin
            // A byte arriving with start_load is dropped on purpose.
            if (bus.start_load) begin
               state_d = StLenHi;
               cnt_d   = '0;
               xor_d   = '0;
               timer_d = '0;
            end
         end

         StLenHi: begin
            if (bus.rx_valid) begin
               len_hi_d = bus.rx_data;
               state_d  = StLenLo;
            end
         end

         StLenLo: begin
            if (bus.rx_valid) begin
               remain_d = len_n;
               if (len_n == 16'd0) begin
                  state_d = StCsum;
               end else if (32'(len_n) > MAX_INSTR) begin
                  state_d = StError;
               end else begin
                  state_d = StB0;
               end
            end
         end

         StB0: begin
            if (bus.rx_valid) begin
               if (bus.rx_data[7:4] != 4'd0) begin
                  state_d = StError;
               end else begin
                  b0_lo_d = bus.rx_data[3:0];
                  xor_d   = xor_q ^ bus.rx_data;
                  state_d = StB1;
               end
            end
         end

         StB1: begin
            if (bus.rx_valid) begin
               b1_d    = bus.rx_data;
               xor_d   = xor_q ^ bus.rx_data;
               state_d = StB2;
            end
         end

         StB2: begin
            if (bus.rx_valid) begin
               // Word and address are registered here; wren follows for one cycle.
               wren_d   = 1'b1;
               addr_d   = cnt_q;
               data_d   = INSTR_WIDTH'({b0_lo_q, b1_q, bus.rx_data});
               cnt_d    = cnt_q + 1'b1;
               remain_d = remain_q - 1'b1;
               xor_d    = xor_q ^ bus.rx_data;
               state_d  = (remain_q == 16'd1) ? StCsum : StB0;
            end
         end

         StCsum: begin
            if (bus.rx_valid) begin
               state_d = (bus.rx_data == xor_q) ? StDone : StError;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      // Inter-byte watchdog; only idle cycles inside a session count.
      if (in_session) begin
         if (bus.rx_valid) begin
            timer_d = '0;
         end else begin
            timer_d = timer_q + 1'b1;
            if (timer_q == TimerWidth'(TIMEOUT_CYCLES - 1)) begin
               state_d = StError;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         timer_q  <= '0;
         xor_q    <= '0;
         len_hi_q <= '0;
         remain_q <= '0;
         b0_lo_q  <= '0;
         b1_q     <= '0;
         cnt_q    <= '0;
         wren_q   <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         xor_q    <= xor_d;
         len_hi_q <= len_hi_d;
         remain_q <= remain_d;
         b0_lo_q  <= b0_lo_d;
         b1_q     <= b1_d;
         cnt_q    <= cnt_d;
         wren_q   <= wren_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.imem_wren    = wren_q;
   assign bus.imem_address = addr_q;
   assign bus.imem_data    = data_q;
   assign bus.cpu_reset    = (state_q != StDone);
   assign bus.load_done    = (state_q == StDone);
   assign bus.load_error   = (state_q == StError);

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

   localparam int unsigned AW   = 16;
   localparam int unsigned IW   = 20;
   localparam int unsigned MAXI = 1024;
   localparam int unsigned TMO  = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   imem_boot_loader_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

   imem_boot_loader #(
      .ADDR_WIDTH     (AW),
      .INSTR_WIDTH    (IW),
      .MAX_INSTR      (MAXI),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [IW-1:0] data;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_out[$];   // 0 = done, 1 = error
   int  checks = 0;
   int  passes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   task automatic model_push(input logic [7:0] f[$]);
      int         n;
      logic [7:0] x;
      wr_t        w;
      n = int'({f[0], f[1]});
      if (n > int'(MAXI)) begin
         exp_out.push_back(1);
         return;
      end
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         if (f[2 + 3*i][7:4] != 4'h0) begin
            exp_out.push_back(1);
            return;
         end
         w.addr = AW'(i);
         w.data = {f[2 + 3*i][3:0], f[3 + 3*i], f[4 + 3*i]};
         exp_wr.push_back(w);
         x = x ^ f[2 + 3*i] ^ f[3 + 3*i] ^ f[4 + 3*i];
      end
      exp_out.push_back((f[2 + 3*n] == x) ? 0 : 1);
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic wren_prev, done_prev, err_prev;
   always @(negedge clk) begin
      wr_t w;
      int  o;
      if (reset) begin
         wren_prev = 1'b0;
         done_prev = 1'b0;
         err_prev  = 1'b0;
      end else begin
         if (bus.imem_wren) begin
            check("wren_single_cycle", 64'(wren_prev), 64'd0);
            if (exp_wr.size() == 0) begin
               checks++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                        bus.imem_address, bus.imem_data);
            end else begin
               w = exp_wr.pop_front();
               check("wr_addr", 64'(bus.imem_address), 64'(w.addr));
               check("wr_data", 64'(bus.imem_data), 64'(w.data));
            end
         end
         if ((bus.load_done && !done_prev) || (bus.load_error && !err_prev)) begin
            if (exp_out.size() == 0) begin
               checks++;
               $display("FAIL unexpected_outcome: got done=%0b error=%0b expected none",
                        bus.load_done, bus.load_error);
            end else begin
               o = exp_out.pop_front();
               check("outcome_done_error", 64'({bus.load_done, bus.load_error}),
                     (o == 0) ? 64'b10 : 64'b01);
               check("outcome_cpu_reset", 64'(bus.cpu_reset), (o == 0) ? 64'd0 : 64'd1);
            end
         end
         wren_prev = bus.imem_wren;
         done_prev = bus.load_done;
         err_prev  = bus.load_error;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pulse(input bit junk);
      bus.start_load = 1'b1;
      bus.rx_valid   = junk;
      bus.rx_data    = 8'($urandom);
      tick();
      bus.start_load = 1'b0;
      bus.rx_valid   = 1'b0;
   endtask

   task automatic drive_bytes(input logic [7:0] f[$], input int mingap, input int maxgap);
      foreach (f[i]) begin
         bus.rx_valid = 1'b1;
         bus.rx_data  = f[i];
         tick();
         bus.rx_valid = 1'b0;
         repeat ($urandom_range(maxgap, mingap)) tick();
      end
   endtask

   task automatic wait_idle(input int budget);
      int i = 0;
      while ((exp_wr.size() != 0 || exp_out.size() != 0) && i < budget) begin
         tick();
         i++;
      end
      if (exp_wr.size() != 0 || exp_out.size() != 0) begin
         checks++;
         $display("FAIL wait_budget: got %0d writes and %0d outcomes pending expected 0",
                  exp_wr.size(), exp_out.size());
         exp_wr.delete();
         exp_out.delete();
      end
   endtask

   task automatic run_frame(input logic [7:0] f[$], input int mingap, input int maxgap,
                            input bit junk);
      model_push(f);
      start_pulse(junk);
      drive_bytes(f, mingap, maxgap);
      wait_idle(64);
   endtask

   task automatic build_frame(input int n, input bit bad_nib, input bit bad_csum,
                              output logic [7:0] f[$]);
      logic [7:0] x, b;
      int         bad_i;
      f.delete();
      f.push_back(8'(n >> 8));
      f.push_back(8'(n));
      x     = 8'h00;
      bad_i = (n > 0) ? int'($urandom_range(n - 1, 0)) : -1;
      for (int i = 0; i < n; i++) begin
         b = {4'h0, 4'($urandom)};
         if (bad_nib && i == bad_i) b[7:4] = 4'($urandom_range(15, 1));
         f.push_back(b);
         x ^= b;
         for (int k = 0; k < 2; k++) begin
            b = 8'($urandom);
            f.push_back(b);
            x ^= b;
         end
      end
      if (bad_csum) x ^= 8'($urandom_range(255, 1));
      f.push_back(x);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] f[$];
      int         n, mode, big;

      bus.start_load = 1'b0;
      bus.rx_valid   = 1'b0;
      bus.rx_data    = 8'h00;
      reset          = 1'b1;
      repeat (2) tick();
      check("rst_wren",    64'(bus.imem_wren),    64'd0);
      check("rst_address", 64'(bus.imem_address), 64'd0);
      check("rst_data",    64'(bus.imem_data),    64'd0);
      check("rst_cpu_reset", 64'(bus.cpu_reset),  64'd1);
      check("rst_done",    64'(bus.load_done),    64'd0);
      check("rst_error",   64'(bus.load_error),   64'd0);
      reset = 1'b0;
      tick();

      // Two-word image with matching checksum
      f = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h0F, 8'hFF, 8'hFF, 8'h68};
      run_frame(f, 0, 2, 1'b0);
      check("t1_done",      64'(bus.load_done),  64'd1);
      check("t1_cpu_reset", 64'(bus.cpu_reset),  64'd0);

      // Same image, wrong checksum
      f = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h0F, 8'hFF, 8'hFF, 8'h00};
      run_frame(f, 0, 2, 1'b0);
      check("t2_error",     64'(bus.load_error), 64'd1);
      check("t2_done",      64'(bus.load_done),  64'd0);
      check("t2_cpu_reset", 64'(bus.cpu_reset),  64'd1);

      // Back-to-back bytes, N=3
      build_frame(3, 1'b0, 1'b0, f);
      run_frame(f, 0, 0, 1'b0);

      // Empty image, then oversize length
      f = '{8'h00, 8'h00, 8'h00};
      run_frame(f, 0, 1, 1'b1);
      check("t4_empty_done", 64'(bus.load_done), 64'd1);
      f = '{8'h04, 8'h01};
      run_frame(f, 0, 0, 1'b0);
      check("t4_oversize_error", 64'(bus.load_error), 64'd1);

      // Largest accepted image, back-to-back
      build_frame(int'(MAXI), 1'b0, 1'b0, f);
      model_push(f);
      start_pulse(1'b0);
      drive_bytes(f, 0, 0);
      wait_idle(64);

      // Non-zero upper nibble in B0
      f = '{8'h00, 8'h01, 8'h10, 8'h00, 8'h00, 8'h10};
      run_frame(f, 0, 0, 1'b0);

      // Watchdog: silence after start_load
      exp_out.push_back(1);
      start_pulse(1'b0);
      repeat (TMO - 2) tick();
      check("t5_no_early_timeout", 64'(bus.load_error), 64'd0);
      wait_idle(6);

      // Long but legal gaps between bytes
      build_frame(2, 1'b0, 1'b0, f);
      run_frame(f, TMO - 2, TMO - 2, 1'b0);
      check("t5_long_gap_done", 64'(bus.load_done), 64'd1);

      // Reset after the first write of a three-word session
      begin
         wr_t w;
         w.addr = '0;
         w.data = 20'hABCDE;
         exp_wr.push_back(w);
         start_pulse(1'b0);
         f = '{8'h00, 8'h03, 8'h0A, 8'hBC, 8'hDE};
         drive_bytes(f, 0, 0);
         wait_idle(8);
         reset = 1'b1;
         #2;
         check("t6_wren",      64'(bus.imem_wren),    64'd0);
         check("t6_address",   64'(bus.imem_address), 64'd0);
         check("t6_data",      64'(bus.imem_data),    64'd0);
         check("t6_cpu_reset", 64'(bus.cpu_reset),    64'd1);
         check("t6_done",      64'(bus.load_done),    64'd0);
         check("t6_error",     64'(bus.load_error),   64'd0);
         tick();
         reset = 1'b0;
         tick();
         build_frame(3, 1'b0, 1'b0, f);
         run_frame(f, 0, 1, 1'b0);
         check("t6_reload_done", 64'(bus.load_done), 64'd1);
      end

      // Randomized sessions
      for (int s = 0; s < 40; s++) begin
         n    = int'($urandom_range(6, 0));
         mode = int'($urandom_range(9, 0));
         if (mode == 2) begin
            big = int'($urandom_range(65535, MAXI + 1));
            f   = '{8'(big >> 8), 8'(big)};
         end else begin
            build_frame(n, (mode == 1) && (n > 0), mode == 0, f);
         end
         run_frame(f, 0, ($urandom_range(7, 0) == 0) ? 10 : 3, 1'($urandom));
      end

      repeat (4) tick();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
